// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier datapath and its BCD display consumer:
// converter state encoding, default sizes and the double-dabble correction constants.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DIGITS = 3;

  // A digit at or above the threshold would reach 10 or more after the next
  // doubling, so it is pre-corrected by the adjust value before the shift.
  localparam logic [3:0] BCD_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJUST = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble correction cell for a single BCD digit.
module bcd_digit_adjust
  import multiplier_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add 3 to digits of 5 or more; the 4-bit sum cannot carry for legal digits.
  always_comb begin
    dout = din;
    if (din >= BCD_THRESH) begin
      dout = din + BCD_ADJUST;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Converts each newly completed multiplier product to decimal digits with a
// bit-serial double-dabble. The displayed digits only change when a conversion
// finishes, so the seven-segment driver never sees intermediate values.
module product_bcd_converter
  import multiplier_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      product,
  input  logic                  productDone,
  output logic [4*DIGITS-1:0]   bcdDigits,
  output logic                  bcdDone,
  output logic                  busy
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam int SHIFT_W = BCD_W + WIDTH;

  state_e             state_r, state_s;
  logic [WIDTH-1:0]   bin_r, bin_s;
  logic [BCD_W-1:0]   bcd_r, bcd_s;
  logic [BCD_W-1:0]   adj_s;
  logic [SHIFT_W-1:0] shifted_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [BCD_W-1:0]   digits_s;
  logic               done_s;
  logic               busy_s;
  logic               done_q_r;
  logic               trig_s;

  // Only a fresh rising edge of the multiplier's done level starts a conversion.
  assign trig_s = productDone & ~done_q_r;

  // Correct every digit of the working register before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (bcd_r[4*g +: 4]),
      .dout (adj_s[4*g +: 4])
    );
  end

  // Shifting the corrected digits and the remaining binary bits as one word
  // moves the next binary MSB into the ones digit.
  assign shifted_s = {adj_s, bin_r} << 1'b1;

  // Next-state and next-output logic; triggers outside IDLE are dropped.
  always_comb begin
    state_s  = state_r;
    bin_s    = bin_r;
    bcd_s    = bcd_r;
    cnt_s    = cnt_r;
    digits_s = bcdDigits;
    done_s   = 1'b0;
    busy_s   = busy;
    case (state_r)
      IDLE: begin
        if (trig_s) begin
          bin_s   = product;
          bcd_s   = '0;
          cnt_s   = CNT_W'(WIDTH);
          busy_s  = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        bcd_s = shifted_s[SHIFT_W-1:WIDTH];
        bin_s = shifted_s[WIDTH-1:0];
        cnt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        digits_s = bcd_r;
        done_s   = 1'b1;
        busy_s   = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs; reset abandons any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bin_r     <= '0;
      bcd_r     <= '0;
      cnt_r     <= '0;
      bcdDigits <= '0;
      bcdDone   <= 1'b0;
      busy      <= 1'b0;
      done_q_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      bin_r     <= bin_s;
      bcd_r     <= bcd_s;
      cnt_r     <= cnt_s;
      bcdDigits <= digits_s;
      bcdDone   <= done_s;
      busy      <= busy_s;
      done_q_r  <= productDone;
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: a constant table, corner-case
// sequences, random multiplier products and a full 8-bit sweep, all checked
// against a decimal model built from integer division.
module tb_product_bcd_converter;

  typedef struct {
    logic [7:0]  product;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  product;
  logic        productDone;
  logic [11:0] bcdDigits;
  logic        bcdDone;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl[10];

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .product     (product),
    .productDone (productDone),
    .bcdDigits   (bcdDigits),
    .bcdDone     (bcdDone),
    .busy        (busy)
  );

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One conversion: rising edge of productDone, then latency, busy width,
  // stable display, result and single-cycle pulse are all checked.
  task automatic run_conv(input logic [7:0] p, input bit hold, input logic [11:0] exp,
                          input string name);
    logic [11:0] prev;
    int          cycles;
    int          busy_cnt;
    bit          moved;
    @(negedge clk);
    product     = p;
    productDone = 1'b1;
    prev        = bcdDigits;
    @(posedge clk);
    @(negedge clk);
    if (!hold) productDone = 1'b0;
    busy_cnt = busy ? 1 : 0;
    cycles   = 0;
    moved    = (bcdDigits !== prev) || (bcdDone === 1'b1);
    while (bcdDone !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (bcdDone !== 1'b1 && bcdDigits !== prev) moved = 1'b1;
    end
    chk({name, " latency"}, 32'(cycles), 32'd9);
    chk({name, " busy_cycles"}, 32'(busy_cnt), 32'd9);
    chk({name, " display_stable"}, 32'(moved), 32'd0);
    chk({name, " digits"}, 32'(bcdDigits), 32'(exp));
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({name, " pulse_width"}, 32'(bcdDone), 32'd0);
  endtask

  initial begin
    int extra;
    int cycles;
    logic [3:0] a;
    logic [3:0] b;

    tbl[0] = '{8'd225, 12'h225};
    tbl[1] = '{8'd0,   12'h000};
    tbl[2] = '{8'd255, 12'h255};
    tbl[3] = '{8'd1,   12'h001};
    tbl[4] = '{8'd9,   12'h009};
    tbl[5] = '{8'd10,  12'h010};
    tbl[6] = '{8'd100, 12'h100};
    tbl[7] = '{8'd199, 12'h199};
    tbl[8] = '{8'd144, 12'h144};
    tbl[9] = '{8'd59,  12'h059};

    // Reset state.
    rst         = 1'b1;
    productDone = 1'b0;
    product     = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset digits", 32'(bcdDigits), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(bcdDone), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle no pulse", 32'(bcdDone), 32'd0);

    // Table-driven conversions; each value must hold until the next trigger.
    for (int i = 0; i < 10; i++) begin
      run_conv(tbl[i].product, 1'b0, tbl[i].exp, "table");
      repeat (3) @(negedge clk);
      chk("table hold", 32'(bcdDigits), 32'(tbl[i].exp));
    end

    // productDone held high: exactly one conversion.
    run_conv(8'd99, 1'b1, 12'h099, "held");
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bcdDone === 1'b1) extra++;
    end
    chk("held extra pulses", 32'(extra), 32'd0);
    chk("held digits", 32'(bcdDigits), 32'h099);
    productDone = 1'b0;
    @(negedge clk);

    // New edge and product change mid-shift are ignored.
    product     = 8'd36;
    productDone = 1'b1;
    @(posedge clk);
    @(negedge clk);
    productDone = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    product     = 8'd200;
    productDone = 1'b1;
    cycles = 0;
    while (bcdDone !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    chk("ignore digits", 32'(bcdDigits), 32'h036);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bcdDone === 1'b1) extra++;
    end
    chk("ignore extra pulses", 32'(extra), 32'd0);
    chk("ignore busy after", 32'(busy), 32'd0);
    chk("ignore digits hold", 32'(bcdDigits), 32'h036);
    productDone = 1'b0;
    @(negedge clk);

    // Reset mid-conversion clears the display and returns to idle.
    product     = 8'd144;
    productDone = 1'b1;
    @(posedge clk);
    @(negedge clk);
    productDone = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midreset busy before", 32'(busy), 32'd1);
    chk("midreset digits before", 32'(bcdDigits), 32'h036);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset digits", 32'(bcdDigits), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(bcdDone), 32'd0);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bcdDone === 1'b1 || busy === 1'b1) extra++;
    end
    chk("midreset stays idle", 32'(extra), 32'd0);
    run_conv(8'd144, 1'b0, 12'h144, "after reset");

    // Random 4x4 multiplier products.
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(15, 0));
      b = 4'($urandom_range(15, 0));
      run_conv(8'(a) * 8'(b), 1'b0, ref_bcd(int'(a) * int'(b)), "random");
    end

    // Every 8-bit product value.
    for (int i = 0; i < 256; i++) begin
      run_conv(8'(i), 1'b0, ref_bcd(i), "sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
